// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - decodes "SET <n>\n" / "RST\n" UART lines into a value and strobes
// Optional `UART_CMD_CR_EN: 0x0D bytes are ignored in every state so CRLF lines parse like LF lines.
module uart_cmd_parser #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] cmd_value,
  output logic        cmd_set,
  output logic        cmd_reset,
  output logic        cmd_error
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] S_E     = 4'd1;
  localparam logic [3:0] S_T     = 4'd2;
  localparam logic [3:0] S_SP    = 4'd3;
  localparam logic [3:0] DIGITS  = 4'd4;
  localparam logic [3:0] R_S     = 4'd5;
  localparam logic [3:0] R_T     = 4'd6;
  localparam logic [3:0] R_NL    = 4'd7;
  localparam logic [3:0] DISCARD = 4'd8;

  localparam logic [2:0] MAX_D = 3'(MAX_DIGITS);

  logic [3:0]  state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic [2:0]  ndig_q, ndig_d;
  logic [15:0] value_q, value_d;
  logic        set_q, set_d;
  logic        reset_q, reset_d;
  logic        error_q, error_d;

  logic        skip;
  logic        bad;
  logic        is_nl;
  logic        is_digit;
  logic [19:0] prod;

`ifdef UART_CMD_CR_EN
  assign skip = (rx_data == 8'h0D);
`else
  assign skip = 1'b0;
`endif

  assign is_nl    = (rx_data == 8'h0A);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign prod     = ({3'b000, acc_q} * 20'd10) + {16'd0, rx_data[3:0]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    value_d = value_q;
    set_d   = 1'b0;
    reset_d = 1'b0;
    error_d = 1'b0;
    bad     = 1'b0;

    if (rx_valid && !skip) begin
      case (state_q)
        IDLE: begin
          if (rx_data == 8'h53)      state_d = S_E;
          else if (rx_data == 8'h52) state_d = R_S;
          else if (!is_nl)           bad = 1'b1;
        end
        S_E:  if (rx_data == 8'h45) state_d = S_T;  else bad = 1'b1;
        S_T:  if (rx_data == 8'h54) state_d = S_SP; else bad = 1'b1;
        S_SP: begin
          if (rx_data == 8'h20) begin
            state_d = DIGITS;
            acc_d   = '0;
            ndig_d  = '0;
          end else begin
            bad = 1'b1;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            // Digit-count and 16-bit overflow both reject the line.
            if (ndig_q == MAX_D || prod > 20'd65535) begin
              bad = 1'b1;
            end else begin
              acc_d  = prod[16:0];
              ndig_d = ndig_q + 3'd1;
            end
          end else if (is_nl && ndig_q != 3'd0) begin
            value_d = acc_q[15:0];
            set_d   = 1'b1;
            state_d = IDLE;
          end else begin
            bad = 1'b1;
          end
        end
        R_S:  if (rx_data == 8'h53) state_d = R_T;  else bad = 1'b1;
        R_T:  if (rx_data == 8'h54) state_d = R_NL; else bad = 1'b1;
        R_NL: begin
          if (is_nl) begin
            reset_d = 1'b1;
            state_d = IDLE;
          end else begin
            bad = 1'b1;
          end
        end
        DISCARD: if (is_nl) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // A stray newline ends the line immediately; anything else drains to newline.
    if (bad) begin
      error_d = 1'b1;
      state_d = is_nl ? IDLE : DISCARD;
    end

    if (state_d == IDLE) begin
      acc_d  = '0;
      ndig_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ndig_q  <= '0;
      value_q <= '0;
      set_q   <= 1'b0;
      reset_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      value_q <= value_d;
      set_q   <= set_d;
      reset_q <= reset_d;
      error_q <= error_d;
    end
  end

  assign cmd_value = value_q;
  assign cmd_set   = set_q;
  assign cmd_reset = reset_q;
  assign cmd_error = error_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] cmd_value;
  logic        cmd_set;
  logic        cmd_reset;
  logic        cmd_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_set    = 0;
  int n_rst    = 0;
  int n_err    = 0;

  uart_cmd_parser #(.MAX_DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_value (cmd_value),
    .cmd_set   (cmd_set),
    .cmd_reset (cmd_reset),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (cmd_set)   n_set++;
    if (cmd_reset) n_rst++;
    if (cmd_error) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    n_set = 0;
    n_rst = 0;
    n_err = 0;
  endtask

  initial begin
    do_reset();
    check("reset_value", 32'(cmd_value), 0);
    check("reset_pulses", {29'd0, cmd_set, cmd_reset, cmd_error}, 0);
    clear_counts();

    // SET 42 back-to-back
    send_str("SET 42\n", 0);
    idle(1);
    check("set42_pulse", 32'(cmd_set), 1);
    check("set42_value", 32'(cmd_value), 42);
    check("set42_noerr", 32'(cmd_error), 0);
    idle(1);
    check("set42_pulse_end", 32'(cmd_set), 0);
    check("set42_count", 32'(n_set), 1);

    // Largest value, then overflow on final digit
    clear_counts();
    send_str("SET 65535\n", 0);
    idle(1);
    check("max_value", 32'(cmd_value), 65535);
    check("max_set", 32'(cmd_set), 1);
    send_str("SET 6553", 0);
    idle(1);
    check("ovf_noerr_early", 32'(n_err), 0);
    send_byte(8'h36);
    idle(1);
    check("ovf_err_pulse", 32'(cmd_error), 1);
    send_str("\n", 0);
    idle(1);
    check("ovf_discard_nopulse", 32'(cmd_error), 0);
    check("ovf_counts", {n_set[15:0], n_err[15:0]}, {16'd1, 16'd1});
    check("ovf_value_held", 32'(cmd_value), 65535);

    // Six digits: fifth accepted, sixth rejected
    clear_counts();
    send_str("SET 00012", 0);
    idle(1);
    check("dig5_noerr", 32'(n_err), 0);
    send_byte(8'h33);
    idle(1);
    check("dig6_err", 32'(cmd_error), 1);
    send_str("\n", 0);
    idle(2);
    check("dig6_counts", {n_set[15:0], n_err[15:0]}, {16'd0, 16'd1});
    check("dig6_value", 32'(cmd_value), 65535);

    // Empty digit field
    clear_counts();
    send_str("SET \n", 0);
    idle(1);
    check("nodig_err", 32'(cmd_error), 1);
    check("nodig_noset", 32'(n_set), 0);

    // Blank line, then a line right after the stray-newline error parses from IDLE
    clear_counts();
    send_str("\n", 0);
    idle(2);
    check("blank_nopulse", 32'(n_set + n_rst + n_err), 0);

    // Garbage line then RST, with idle gaps
    clear_counts();
    send_str("X", 2);
    check("xyz_err_after_x", 32'(n_err), 1);
    send_str("YZ\nRST", 2);
    send_byte(8'h0A);
    idle(1);
    check("rst_pulse", 32'(cmd_reset), 1);
    idle(1);
    check("xyz_counts", {n_rst[15:0], n_err[15:0]}, {16'd1, 16'd1});
    check("rst_value_held", 32'(cmd_value), 65535);

    // Lowercase rejected
    clear_counts();
    send_str("set 1\n", 0);
    idle(1);
    check("lower_counts", {n_set[15:0], n_err[15:0]}, {16'd0, 16'd1});

    // Reset mid-line
    clear_counts();
    send_str("SET 12", 0);
    do_reset();
    check("midrst_value", 32'(cmd_value), 0);
    send_str("SET 7\n", 0);
    idle(1);
    check("midrst_value7", 32'(cmd_value), 7);
    check("midrst_counts", {n_set[15:0], n_err[15:0]}, {16'd1, 16'd0});

    // Reset wins over a simultaneous byte: 'R' dropped, so "ST\n" is an error
    clear_counts();
    @(negedge clk);
    rst      = 1'b1;
    rx_data  = 8'h52;
    rx_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    send_str("ST\n", 0);
    idle(2);
    check("rst_drop_counts", {n_rst[15:0], n_err[15:0]}, {16'd0, 16'd1});

    // CRLF line
    clear_counts();
    send_str("SET 9\r\n", 0);
    idle(2);
`ifdef UART_CMD_CR_EN
    check("crlf_value", 32'(cmd_value), 9);
    check("crlf_counts", {n_set[15:0], n_err[15:0]}, {16'd1, 16'd0});
`else
    check("crlf_value", 32'(cmd_value), 0);
    check("crlf_counts", {n_set[15:0], n_err[15:0]}, {16'd0, 16'd1});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Receive-side companion to the button message transmitter: consumes the UART RX byte stream and decodes newline-terminated ASCII command lines into a 16-bit value and command strobes. Sits between the UART receiver and the counter/display logic. It lets a host set the sequence counter (`SET <n>\n`) or clear it (`RST\n`). Malformed lines are reported and discarded without disturbing the held value.

## Interface
Parameters:
- `MAX_DIGITS`, 5, maximum decimal digits accepted after `SET `, range 1..5.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte; no backpressure, every strobe is consumed.
- `cmd_value`  out  16  last successfully parsed `SET` value; holds between commands.
- `cmd_set`  out  1  one-cycle pulse: `cmd_value` updated.
- `cmd_reset`  out  1  one-cycle pulse: `RST` line accepted.
- `cmd_error`  out  1  one-cycle pulse: malformed line detected.

## Operation
- States: `IDLE`, `S_E`, `S_T`, `S_SP`, `DIGITS`, `R_S`, `R_T`, `R_NL`, `DISCARD`.
- `IDLE`: `S`→`S_E`; `R`→`R_S`; `\n` (0x0A) ignored, empty line, no error; any other byte→error.
- `S_E` expects `E`, `S_T` expects `T`, `S_SP` expects 0x20, then `DIGITS`. `R_S` expects `S`, `R_T` expects `T`, then `R_NL` expects `\n`.
- `DIGITS`: `0`-`9` → `acc <= acc*10 + (byte-0x30)`, `ndig++`; `\n` with `ndig`≥1 → `cmd_value <= acc[15:0]`, `cmd_set` pulse, `IDLE`.
- `R_NL` on `\n` → `cmd_reset` pulse, `IDLE`.
- Arithmetic: `acc` is 17 bits, product is computed at 20 bits. If the result exceeds 65535, that is an error. Leading zeros are allowed and count toward `ndig`. A digit arriving when `ndig`==`MAX_DIGITS` is an error.
- Error rules, all non-`\n` unexpected bytes:
  - Pulse `cmd_error`, go to `DISCARD`.
  - `DISCARD` drops bytes until `\n`, then goes to `IDLE` with no further pulse.
- Unexpected `\n` mid-command, including `\n` in `DIGITS` with `ndig`=0: pulse `cmd_error`, go directly to `IDLE`.
- `acc` and `ndig` clear on every entry to `IDLE` and on entry to `S_SP`→`DIGITS`.
- Commands are case-sensitive; lowercase is an error.
- At most one of `cmd_set`/`cmd_reset`/`cmd_error` is high in any cycle.

## Timing
- Reset: state `IDLE`; `cmd_value`=0, `cmd_set`=0, `cmd_reset`=0, `cmd_error`=0; `acc`=0, `ndig`=0.
- Latency: a strobe is registered on the edge where `rx_valid`=1. `cmd_set`/`cmd_reset`/`cmd_error` are high for exactly the following cycle.
- `cmd_value` changes in the same cycle `cmd_set` is high.
- Back-to-back `rx_valid` on consecutive cycles are fully supported; no byte is dropped.
- Cycles with `rx_valid`=0 leave all state unchanged and outputs other than `cmd_value` at 0.
- `rst` mid-line: line abandoned, no pulse. The next byte is parsed from `IDLE`. `cmd_value` returns to 0.
- `rst` and `rx_valid` high in the same cycle: reset wins, byte dropped.

## Configuration
- `UART_CMD_CR_EN` defined: byte 0x0D is ignored in every state, with no state change, so CRLF lines parse identically to LF lines.
- Undefined: 0x0D is an ordinary byte and is treated as an unexpected byte (error/`DISCARD`) in every state except `DISCARD`.

## Test plan
- Reset, then `SET 42\n` at one byte per cycle → single `cmd_set` pulse the cycle after `\n`; `cmd_value`=42; no `cmd_error`.
- `SET 65535\n` then `SET 65536\n` → `cmd_value`=65535 with `cmd_set`. The second line gives `cmd_error` on its final `6`, no `cmd_set`, and `cmd_value` stays 65535.
- Each line checked separately:
  - `SET 000123\n` → error on the 6th digit, discard to `\n`, value unchanged.
  - `SET \n` → error on `\n`.
  - `\n` alone → no pulse.
- `XYZ\nRST\n` with idle gaps between bytes → one `cmd_error` after `X`, then one `cmd_reset` after the second `\n`; `cmd_value` unchanged.
- `SET 12` then `rst`, then `SET 7\n` → no pulse from the partial line; `cmd_value` goes 0 then 7.
- `SET 9\r\n` → with `UART_CMD_CR_EN`: `cmd_set`, value 9. Without it: `cmd_error` on 0x0D and no `cmd_set`.
